// File: rtl/rep_buffer_if.sv
// Handshake and status bundle between the DLL TX framer/replay path and rep_buffer_ctrl.
// The controller connects through the slave modport and the framer side through master.
interface rep_buffer_if #(
  parameter int MAX_ADDR_SIZE = 8
);
  logic                     wr_req;
  logic                     ack_valid;
  logic                     nak_valid;
  logic [11:0]              ack_seq;
  logic                     tx_ready;
  logic                     wr_en;
  logic                     rd_en;
  logic [MAX_ADDR_SIZE-1:0] wr_ptr;
  logic [MAX_ADDR_SIZE-1:0] rd_ptr;
  logic [MAX_ADDR_SIZE:0]   count;
  logic [2:0]               segment_count;
  logic                     tx_hold;
  logic                     replay_active;
  logic                     retrain_req;
  logic                     dllp_err;

  modport slave (
    input  wr_req, ack_valid, nak_valid, ack_seq, tx_ready,
    output wr_en, rd_en, wr_ptr, rd_ptr, count, segment_count,
           tx_hold, replay_active, retrain_req, dllp_err
  );

  modport master (
    output wr_req, ack_valid, nak_valid, ack_seq, tx_ready,
    input  wr_en, rd_en, wr_ptr, rd_ptr, count, segment_count,
           tx_hold, replay_active, retrain_req, dllp_err
  );
endinterface

// File: rtl/rep_buffer_ctrl.sv
// DLL TX replay buffer sequencer: pointers, occupancy, ACK/NAK purge, replay timer,
// REPLAY_NUM tracking and the three-segment replay read of unacknowledged entries.
module rep_buffer_ctrl #(
  parameter int MAX_ADDR_SIZE      = 8,
  parameter int BUFF_DEPTH         = 256,
  parameter int REPLAY_TIMER_LIMIT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  rep_buffer_if.slave  bus
);
  localparam int PW = MAX_ADDR_SIZE;
  localparam int CW = MAX_ADDR_SIZE + 1;
  localparam int TW = $clog2(REPLAY_TIMER_LIMIT + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(BUFF_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [11:0]   SEQ_ONE  = 12'd1;
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [TW-1:0] TMR_ZERO = TW'(0);
  localparam logic [TW-1:0] TMR_LAST = TW'(REPLAY_TIMER_LIMIT - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REPLAY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] end_q, end_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    seg_q, seg_d;
  logic [11:0]   acked_q, acked_d;
  logic [11:0]   next_seq_q, next_seq_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    rnum_q, rnum_d;
  logic          pend_valid_q, pend_valid_d;
  logic          pend_nak_q, pend_nak_d;
  logic [11:0]   pend_seq_q, pend_seq_d;
  logic          retrain_q, retrain_d;
  logic          err_q, err_d;

  logic          in_idle_s, in_replay_s, new_dllp_s;
  logic          eff_valid_s, eff_nak_s;
  logic [11:0]   eff_seq_s, n_s;
  logic          err_s, purge_s;
  logic [CW-1:0] cnt_post_s;
  logic [PW-1:0] head_post_s;
  logic          nak_start_s, tmo_start_s, start_s;
  logic          full_s, tx_hold_s, wr_en_s, end_s;
  logic [1:0]    rnum_base_s;

  assign in_idle_s   = (state_q == ST_IDLE);
  assign in_replay_s = (state_q == ST_REPLAY);
  assign new_dllp_s  = bus.ack_valid | bus.nak_valid;

  // A DLLP held over from a replay merges with any DLLP arriving in the same idle cycle.
  assign eff_valid_s = in_idle_s & (new_dllp_s | pend_valid_q);
  assign eff_seq_s   = new_dllp_s ? bus.ack_seq : pend_seq_q;
  assign eff_nak_s   = bus.nak_valid | pend_nak_q;

  assign n_s         = eff_seq_s - acked_q;
  assign err_s       = eff_valid_s & (n_s > 12'(count_q));
  assign purge_s     = eff_valid_s & ~err_s & (n_s != 12'd0);
  assign cnt_post_s  = purge_s ? (count_q - n_s[CW-1:0]) : count_q;
  assign head_post_s = purge_s ? (head_q + n_s[PW-1:0]) : head_q;

  assign nak_start_s = eff_valid_s & eff_nak_s & ~err_s & (cnt_post_s != CNT_ZERO);
  assign tmo_start_s = in_idle_s & (timer_q == TMR_LAST) & (cnt_post_s != CNT_ZERO) & ~purge_s;
  assign start_s     = nak_start_s | tmo_start_s;

  assign full_s      = (count_q == CNT_FULL);
  assign tx_hold_s   = full_s | in_replay_s | start_s;
  assign wr_en_s     = bus.wr_req & ~tx_hold_s;
  assign end_s       = ((rd_ptr_q + PTR_ONE) == end_q);
  assign rnum_base_s = purge_s ? 2'd0 : rnum_q;

  // Next-state computation for pointers, occupancy, timer, pending slot and FSM.
  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    head_d       = head_post_s;
    end_d        = end_q;
    count_d      = cnt_post_s + CW'(wr_en_s);
    seg_d        = seg_q;
    acked_d      = purge_s ? eff_seq_s : acked_q;
    rnum_d       = rnum_base_s;
    retrain_d    = 1'b0;
    err_d        = err_s;
    pend_valid_d = pend_valid_q;
    pend_nak_d   = pend_nak_q;
    pend_seq_d   = pend_seq_q;

    if (wr_en_s) begin
      wr_ptr_d   = wr_ptr_q + PTR_ONE;
      next_seq_d = next_seq_q + SEQ_ONE;
    end else begin
      wr_ptr_d   = wr_ptr_q;
      next_seq_d = next_seq_q;
    end

    if (in_replay_s) begin
      if (new_dllp_s) begin
        pend_valid_d = 1'b1;
        pend_seq_d   = bus.ack_seq;
        pend_nak_d   = pend_nak_q | bus.nak_valid;
      end else begin
        pend_valid_d = pend_valid_q;
      end
    end else begin
      pend_valid_d = 1'b0;
      pend_nak_d   = 1'b0;
    end

    if ((count_q == CNT_ZERO) || purge_s) begin
      timer_d = TMR_ZERO;
    end else if (in_idle_s && !start_s) begin
      timer_d = timer_q + TMR_ONE;
    end else begin
      timer_d = timer_q;
    end

    case (state_q)
      ST_IDLE: begin
        rd_ptr_d = head_post_s;
        if (start_s) begin
          state_d   = ST_REPLAY;
          seg_d     = 3'd1;
          end_d     = wr_ptr_q;
          rnum_d    = rnum_base_s + 2'd1;
          retrain_d = (rnum_base_s == 2'd3);
        end else begin
          seg_d = 3'd0;
        end
      end
      ST_REPLAY: begin
        if (bus.tx_ready) begin
          if (seg_q == 3'd3) begin
            if (end_s) begin
              state_d  = ST_IDLE;
              seg_d    = 3'd0;
              timer_d  = TMR_ZERO;
              rd_ptr_d = head_q;
            end else begin
              rd_ptr_d = rd_ptr_q + PTR_ONE;
              seg_d    = 3'd1;
            end
          end else begin
            seg_d = seg_q + 3'd1;
          end
        end else begin
          seg_d = seg_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        seg_d   = 3'd0;
      end
    endcase
  end

  // State register; asynchronous reset abandons any in-flight replay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_q       <= '0;
      end_q        <= '0;
      count_q      <= '0;
      seg_q        <= 3'd0;
      acked_q      <= 12'hFFF;
      next_seq_q   <= 12'd0;
      timer_q      <= '0;
      rnum_q       <= 2'd0;
      pend_valid_q <= 1'b0;
      pend_nak_q   <= 1'b0;
      pend_seq_q   <= 12'd0;
      retrain_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_q       <= head_d;
      end_q        <= end_d;
      count_q      <= count_d;
      seg_q        <= seg_d;
      acked_q      <= acked_d;
      next_seq_q   <= next_seq_d;
      timer_q      <= timer_d;
      rnum_q       <= rnum_d;
      pend_valid_q <= pend_valid_d;
      pend_nak_q   <= pend_nak_d;
      pend_seq_q   <= pend_seq_d;
      retrain_q    <= retrain_d;
      err_q        <= err_d;
    end
  end

  assign bus.wr_en         = wr_en_s;
  assign bus.rd_en         = in_replay_s & bus.tx_ready;
  assign bus.wr_ptr        = wr_ptr_q;
  assign bus.rd_ptr        = rd_ptr_q;
  assign bus.count         = count_q;
  assign bus.segment_count = seg_q;
  assign bus.tx_hold       = tx_hold_s;
  assign bus.replay_active = in_replay_s;
  assign bus.retrain_req   = retrain_q;
  assign bus.dllp_err      = err_q;
endmodule

// File: tb/tb_rep_buffer_ctrl.sv
// Directed self-checking bench for rep_buffer_ctrl: writes, ACK purge, NAK/timeout replay,
// full buffer, out-of-range DLLP, pending ACK during replay and asynchronous reset.
module tb_rep_buffer_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rep_buffer_if #(.MAX_ADDR_SIZE(8)) bus ();

  rep_buffer_ctrl #(
    .MAX_ADDR_SIZE(8),
    .BUFF_DEPTH(256),
    .REPLAY_TIMER_LIMIT(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_n(input int k);
    bus.wr_req = 1'b1;
    repeat (k) tick();
    bus.wr_req = 1'b0;
  endtask

  task automatic send_dllp(input logic nak, input logic [11:0] seq);
    bus.ack_valid = ~nak;
    bus.nak_valid = nak;
    bus.ack_seq   = seq;
    tick();
    bus.ack_valid = 1'b0;
    bus.nak_valid = 1'b0;
  endtask

  // Each timeout fires 1024 edges after the buffer became non-empty or the last replay ended.
  task automatic run_timeouts(input int k, input int retrain_at);
    for (int i = 0; i < k; i++) begin
      repeat (1023) tick();
      chk("tmo_not_yet", 32'(bus.replay_active), 32'd0);
      tick();
      chk("tmo_active", 32'(bus.replay_active), 32'd1);
      chk("tmo_retrain", 32'(bus.retrain_req), 32'(i == retrain_at));
      repeat (3) tick();
      chk("tmo_done", 32'(bus.replay_active), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.wr_req = 1'b0;
    bus.ack_valid = 1'b0;
    bus.nak_valid = 1'b0;
    bus.ack_seq = 12'd0;
    bus.tx_ready = 1'b1;
    tick();
    tick();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_wr_ptr", 32'(bus.wr_ptr), 32'd0);
    chk("rst_rd_ptr", 32'(bus.rd_ptr), 32'd0);
    chk("rst_seg", 32'(bus.segment_count), 32'd0);
    chk("rst_hold", 32'(bus.tx_hold), 32'd0);
    chk("rst_active", 32'(bus.replay_active), 32'd0);
    chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("rst_retrain", 32'(bus.retrain_req), 32'd0);
    chk("rst_err", 32'(bus.dllp_err), 32'd0);
    rst = 1'b0;

    // Write 4, ACK seq 1 purges seq 0 and 1
    bus.wr_req = 1'b1;
    #1;
    chk("wr_en_comb", 32'(bus.wr_en), 32'd1);
    write_n(4);
    chk("w4_count", 32'(bus.count), 32'd4);
    chk("w4_wr_ptr", 32'(bus.wr_ptr), 32'd4);
    send_dllp(1'b0, 12'd1);
    chk("ack1_count", 32'(bus.count), 32'd2);
    chk("ack1_rd_ptr", 32'(bus.rd_ptr), 32'd2);
    chk("ack1_err", 32'(bus.dllp_err), 32'd0);

    // NAK seq 0 with 3 stored: purge one, replay entries 1 and 2; concurrent write is held off
    do_reset();
    write_n(3);
    bus.nak_valid = 1'b1;
    bus.ack_seq = 12'd0;
    bus.wr_req = 1'b1;
    #1;
    chk("nak_hold", 32'(bus.tx_hold), 32'd1);
    chk("nak_wr_blk", 32'(bus.wr_en), 32'd0);
    tick();
    bus.nak_valid = 1'b0;
    bus.wr_req = 1'b0;
    chk("nak_count", 32'(bus.count), 32'd2);
    for (int c = 0; c < 6; c++) begin
      chk("rp_active", 32'(bus.replay_active), 32'd1);
      chk("rp_seg", 32'(bus.segment_count), 32'((c % 3) + 1));
      chk("rp_rd_ptr", 32'(bus.rd_ptr), 32'(1 + c / 3));
      chk("rp_rd_en", 32'(bus.rd_en), 32'd1);
      tick();
    end
    chk("rp_end_active", 32'(bus.replay_active), 32'd0);
    chk("rp_end_seg", 32'(bus.segment_count), 32'd0);
    chk("rp_end_hold", 32'(bus.tx_hold), 32'd0);
    chk("rp_end_rd_ptr", 32'(bus.rd_ptr), 32'd1);
    chk("rp_end_wr_ptr", 32'(bus.wr_ptr), 32'd3);

    // Replay with tx_ready alternating 0,1: 12 cycles for 2 entries
    send_dllp(1'b1, 12'd0);
    for (int c = 0; c < 12; c++) begin
      bus.tx_ready = (c % 2 == 1);
      #1;
      chk("tg_active", 32'(bus.replay_active), 32'd1);
      chk("tg_seg", 32'(bus.segment_count), 32'(((c / 2) % 3) + 1));
      chk("tg_rd_ptr", 32'(bus.rd_ptr), 32'(1 + (c / 2) / 3));
      chk("tg_rd_en", 32'(bus.rd_en), 32'(c % 2 == 1));
      tick();
    end
    bus.tx_ready = 1'b1;
    chk("tg_end_active", 32'(bus.replay_active), 32'd0);
    chk("tg_end_count", 32'(bus.count), 32'd2);

    // Out-of-range ACK is ignored with an error pulse
    do_reset();
    write_n(3);
    send_dllp(1'b0, 12'd100);
    chk("err_pulse", 32'(bus.dllp_err), 32'd1);
    chk("err_count", 32'(bus.count), 32'd3);
    chk("err_rd_ptr", 32'(bus.rd_ptr), 32'd0);
    tick();
    chk("err_clear", 32'(bus.dllp_err), 32'd0);

    // NAK with n=0 replays all 3; ACK seq 1 during replay is applied after return to idle
    send_dllp(1'b1, 12'hFFF);
    for (int c = 0; c < 9; c++) begin
      bus.ack_valid = (c == 2);
      bus.ack_seq = 12'd1;
      #1;
      chk("pa_active", 32'(bus.replay_active), 32'd1);
      chk("pa_count", 32'(bus.count), 32'd3);
      tick();
    end
    bus.ack_valid = 1'b0;
    chk("pa_idle", 32'(bus.replay_active), 32'd0);
    chk("pa_count_held", 32'(bus.count), 32'd3);
    tick();
    chk("pa_count_applied", 32'(bus.count), 32'd1);
    chk("pa_rd_ptr", 32'(bus.rd_ptr), 32'd2);
    chk("pa_no_replay", 32'(bus.replay_active), 32'd0);

    // Fill to 256, wrap of wr_ptr, full hold, ACK with blocked and unblocked writes
    do_reset();
    write_n(255);
    chk("f255_count", 32'(bus.count), 32'd255);
    chk("f255_wr_ptr", 32'(bus.wr_ptr), 32'd255);
    chk("f255_hold", 32'(bus.tx_hold), 32'd0);
    bus.wr_req = 1'b1;
    tick();
    chk("full_count", 32'(bus.count), 32'd256);
    chk("full_wr_ptr", 32'(bus.wr_ptr), 32'd0);
    chk("full_hold", 32'(bus.tx_hold), 32'd1);
    chk("full_wr_blk", 32'(bus.wr_en), 32'd0);
    tick();
    chk("full_ign_count", 32'(bus.count), 32'd256);
    chk("full_ign_wr_ptr", 32'(bus.wr_ptr), 32'd0);
    send_dllp(1'b0, 12'd7);
    chk("ack7_count", 32'(bus.count), 32'd248);
    chk("ack7_rd_ptr", 32'(bus.rd_ptr), 32'd8);
    chk("ack7_wr_ptr", 32'(bus.wr_ptr), 32'd0);
    bus.wr_req = 1'b1;
    send_dllp(1'b0, 12'd9);
    bus.wr_req = 1'b0;
    chk("ackwr_count", 32'(bus.count), 32'd247);
    chk("ackwr_wr_ptr", 32'(bus.wr_ptr), 32'd1);
    chk("ackwr_rd_ptr", 32'(bus.rd_ptr), 32'd10);

    // Timer replays: retrain on the 4th; forward ACK resets REPLAY_NUM
    do_reset();
    write_n(1);
    run_timeouts(4, 3);
    run_timeouts(2, -1);
    send_dllp(1'b0, 12'd0);
    chk("fwd_count", 32'(bus.count), 32'd0);
    write_n(1);
    run_timeouts(4, 3);

    // Asynchronous reset in the middle of a replay
    send_dllp(1'b1, 12'd0);
    chk("ar_active", 32'(bus.replay_active), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_active_gone", 32'(bus.replay_active), 32'd0);
    chk("ar_count", 32'(bus.count), 32'd0);
    chk("ar_wr_ptr", 32'(bus.wr_ptr), 32'd0);
    chk("ar_seg", 32'(bus.segment_count), 32'd0);
    chk("ar_rd_en", 32'(bus.rd_en), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_post_active", 32'(bus.replay_active), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
